// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction memory write port and status out
`timescale 1ns/1ps
interface program_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to 16-bit instruction memory writes with XOR check
`timescale 1ns/1ps
module program_loader #(
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic             CLK,
    input  logic             RST,
    program_loader_if.slave  bus
);
    localparam int          WW      = ADDR_W + 1;
    localparam logic [16:0] MAX_CNT = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_D_HI, S_D_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt_hi;
    logic [ADDR_W:0]   r_cnt;
    logic [7:0]        r_hi;
    logic [7:0]        r_xor;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic              r_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [15:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic [15:0]       w_cnt;
    logic [ADDR_W:0]   w_words_next;

    assign bus.rx_ready = (r_state != S_DONE);
    assign w_accept     = bus.rx_valid & bus.rx_ready;
    assign w_cnt        = {r_cnt_hi, bus.rx_data};
    assign w_words_next = r_words + WW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt_hi    <= '0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_xor       <= '0;
            r_addr      <= '0;
            r_words     <= '0;
            r_we        <= 1'b0;
            r_imem_addr <= '0;
            r_wdata     <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            r_state <= S_CNT_HI;
                            r_xor   <= '0;
                            r_addr  <= '0;
                            r_words <= '0;
                            r_error <= 1'b0;
                        end
                    end
                    S_CNT_HI: begin
                        r_cnt_hi <= bus.rx_data;
                        r_xor    <= r_xor ^ bus.rx_data;
                        r_state  <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        r_xor <= r_xor ^ bus.rx_data;
                        r_cnt <= w_cnt[ADDR_W:0];
                        if ({1'b0, w_cnt} > MAX_CNT) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (w_cnt == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_D_HI;
                        end
                    end
                    S_D_HI: begin
                        r_hi    <= bus.rx_data;
                        r_xor   <= r_xor ^ bus.rx_data;
                        r_state <= S_D_LO;
                    end
                    S_D_LO: begin
                        // Address wraps only after the last word of a full-memory frame.
                        r_xor       <= r_xor ^ bus.rx_data;
                        r_we        <= 1'b1;
                        r_imem_addr <= r_addr;
                        r_wdata     <= {r_hi, bus.rx_data};
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_words     <= w_words_next;
                        r_state     <= (w_words_next == r_cnt) ? S_CHK : S_D_HI;
                    end
                    S_CHK: begin
                        if (bus.rx_data == r_xor) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_we      = r_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.cpu_rst      = r_cpu_rst;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
`timescale 1ns/1ps
module tb_program_loader;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    program_loader_if #(.ADDR_W(12)) bus();

    program_loader #(.ADDR_W(12), .SYNC_BYTE(8'hA5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];

    logic [7:0] nom[$]  = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    logic [7:0] bad[$]  = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    logic [7:0] emp[$]  = '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    logic [7:0] part[$] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qd(input int i);
        return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 50) begin
            failures++;
            $display("FAIL send_timeout observed=rx_ready_low expected=accept byte=%0h", b);
        end
        @(posedge CLK); #1;
        bus.rx_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int maxgap);
        foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_nominal(input string p);
        chk({p, "_nwr"},   wa_q.size(), 2);
        chk({p, "_a0"},    qa(0), 32'h0);
        chk({p, "_d0"},    qd(0), 32'h1234);
        chk({p, "_a1"},    qa(1), 32'h1);
        chk({p, "_d1"},    qd(1), 32'hABCD);
        chk({p, "_done"},  bus.done, 1);
        chk({p, "_cpu"},   bus.cpu_rst, 0);
        chk({p, "_err"},   bus.error, 0);
        chk({p, "_wl"},    bus.words_loaded, 2);
        chk({p, "_rdy"},   bus.rx_ready, 0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_rdy"},  bus.rx_ready, 1);
        chk({p, "_we"},   bus.imem_we, 0);
        chk({p, "_addr"}, bus.imem_addr, 0);
        chk({p, "_wd"},   bus.imem_wdata, 0);
        chk({p, "_cpu"},  bus.cpu_rst, 1);
        chk({p, "_done"}, bus.done, 0);
        chk({p, "_err"},  bus.error, 0);
        chk({p, "_wl"},   bus.words_loaded, 0);
    endtask

    initial begin
        logic [7:0]  x;
        logic [15:0] w;
        int          seq_err;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        RST = 1'b0;

        // Nominal frame back-to-back: done lands on the CHK accept edge
        clear_q();
        send_seq(nom, 0);
        check_nominal("nom");
        chk("nom_spacing", (wc_q.size() == 2) ? 32'(wc_q[1] - wc_q[0]) : 32'hFFFF, 2);

        // Empty frame after garbage
        do_reset();
        send_seq(emp, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("emp_nwr",  wa_q.size(), 0);
        chk("emp_done", bus.done, 1);
        chk("emp_cpu",  bus.cpu_rst, 0);
        chk("emp_wl",   bus.words_loaded, 0);

        // Bad checksum, then recovery with the good frame
        do_reset();
        send_seq(bad, 0);
        chk("bad_nwr",  wa_q.size(), 2);
        chk("bad_err",  bus.error, 1);
        chk("bad_cpu",  bus.cpu_rst, 1);
        chk("bad_done", bus.done, 0);
        chk("bad_rdy",  bus.rx_ready, 1);
        chk("bad_wl",   bus.words_loaded, 2);
        clear_q();
        send_byte(8'hA5, 0);
        chk("resync_err", bus.error, 0);
        chk("resync_wl",  bus.words_loaded, 0);
        for (int i = 1; i < nom.size(); i++) send_byte(nom[i], 0);
        check_nominal("rec");

        // Oversize count
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        chk("ovr_err", bus.error, 1);
        chk("ovr_cpu", bus.cpu_rst, 1);
        chk("ovr_rdy", bus.rx_ready, 1);
        repeat (2) @(posedge CLK);
        #1;
        chk("ovr_nwr", wa_q.size(), 0);

        // Maximum count fills all 4096 locations
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        x = 8'h10 ^ 8'h00;
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i * 7 + 3);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
            x = x ^ w[15:8] ^ w[7:0];
        end
        send_byte(x, 0);
        @(posedge CLK); #1;
        seq_err = 0;
        for (int i = 0; i < 4096; i++) begin
            if (qa(i) !== 32'(i) || qd(i) !== 32'(16'(i * 7 + 3))) seq_err++;
        end
        chk("max_nwr",   wa_q.size(), 4096);
        chk("max_seq",   seq_err, 0);
        chk("max_alast", qa(4095), 32'hFFF);
        chk("max_dlast", qd(4095), 32'(16'(4095 * 7 + 3)));
        chk("max_wl",    bus.words_loaded, 32'h1000);
        chk("max_done",  bus.done, 1);
        chk("max_cpu",   bus.cpu_rst, 0);

        // Reset in the middle of a frame
        do_reset();
        send_seq(part, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_vals("mid");
        RST = 1'b0;
        clear_q();
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_nowr", wa_q.size(), 0);
        send_seq(nom, 0);
        check_nominal("mid_nom");

        // Random rx_valid gaps
        do_reset();
        send_seq(nom, 3);
        check_nominal("gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that fills the instruction memory the microprocessor fetches from. It receives a framed byte stream (from a UART receiver or a debug port), assembles 16-bit instruction words and writes them sequentially into the instruction memory write port. It verifies an XOR checksum and holds the processor in reset (`cpu_rst`) until a load completes successfully.

## Interface
Parameters:
- `ADDR_W`, default 12: instruction memory address width; matches the 12-bit PC fetch address.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `rx_valid`  in  1  input byte valid.
- `rx_data`  in  8  input byte.
- `rx_ready`  out  1  loader can take a byte; a byte is accepted on an edge where `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  16  instruction word.
- `cpu_rst`  out  1  processor reset request; high until a good load completes.
- `done`  out  1  load completed with a valid checksum.
- `error`  out  1  last frame was rejected.
- `words_loaded`  out  ADDR_W+1  number of words written in the current or last frame.

## Operation
- Frame format: `SYNC_BYTE`, CNT_HI, CNT_LO, then CNT words sent high byte first, then CHK.
  - CHK is the XOR of every byte after SYNC, including both count bytes.
- FSM states: IDLE, CNT_HI, CNT_LO, D_HI, D_LO, CHK, DONE, ERR.
- Transitions, evaluated only on an accepted byte:
  - IDLE: `SYNC_BYTE` -> CNT_HI. Any other byte is discarded.
  - CNT_HI: latch the high count byte -> CNT_LO.
  - CNT_LO: latch the low count byte.
    - CNT > 2^ADDR_W -> ERR.
    - CNT == 0 -> CHK.
    - Otherwise -> D_HI.
  - D_HI: latch the byte as the high half -> D_LO.
  - D_LO: write the word, increment the address.
    - Last word -> CHK.
    - Otherwise -> D_HI.
  - CHK: byte equals the running XOR -> DONE. Otherwise -> ERR.
  - DONE: terminal until RST. `rx_ready` = 0.
  - ERR: `error` = 1, `cpu_rst` = 1, `rx_ready` = 1.
    - Non-SYNC bytes are discarded.
    - `SYNC_BYTE` -> CNT_HI. This clears `error` and `words_loaded`, and restarts the address at 0 and the XOR at 0.
- `rx_ready` is 1 in every state except DONE. It is combinational from the state.
- Word i of a frame is written to address i. Address arithmetic is ADDR_W bits wide. CNT == 2^ADDR_W fills memory exactly, and the address wraps to 0 only after the final write, never during the frame.
- On checksum failure the words already written remain in memory. The CPU is not released.
- Inside a frame, a `SYNC_BYTE` value is treated as ordinary data or count; it is not a resync.
- Gaps in `rx_valid` do not affect state.

## Timing
- Reset values: `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `error`=0, `words_loaded`=0, state IDLE, XOR accumulator 0.
- `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - `imem_we` is high for exactly the one cycle after the edge that accepts a D_LO byte.
  - `imem_addr` and `imem_wdata` are valid in that same cycle.
  - `imem_addr` then advances; `words_loaded` increments on the same edge that sets `imem_we`.
- `done`=1 and `cpu_rst`=0 take effect from the edge that accepts a matching CHK byte, so latency is 0 cycles after acceptance.
- `error`=1 takes effect from the edge that accepts a bad CHK byte or an oversize CNT_LO.
- Throughput: one byte per cycle when `rx_valid` is held high. Back-to-back words therefore produce one `imem_we` pulse every 2 cycles.
- RST asserted mid-frame: on the next edge all outputs return to their reset values and partial data is abandoned. No further `imem_we` pulses occur.
- RST wins over a byte accepted on the same edge.

## Test plan
- Nominal frame, bytes A5 00 02 12 34 AB CD 42 sent back-to-back -> two `imem_we` pulses: addr 0/0x1234, then addr 1/0xABCD. After that, `done`=1, `cpu_rst`=0, `words_loaded`=2, `rx_ready`=0.
- Empty frame A5 00 00 00 -> no `imem_we` pulses, `done`=1, `cpu_rst`=0. Garbage bytes FF 00 sent before it are ignored.
- Bad checksum, same frame as the nominal case but ending 43 -> 2 writes occur, then `error`=1, `cpu_rst`=1, `done`=0. Resending the good frame clears `error` and gives `done`=1.
- Oversize count A5 10 01 with ADDR_W=12 -> `error`=1 on the CNT_LO edge, with no writes. The max count A5 10 00 followed by 4096 words gives a last write at addr 0xFFF and `words_loaded`=4096.
- RST pulsed after the bytes A5 00 02 12 34 AB -> all outputs return to their reset values. A following nominal frame loads correctly starting at addr 0.
- Randomised `rx_valid` gaps on the nominal frame -> the same writes and final flags as the back-to-back case.
